nf_prog_loader: RTL

Byte-stream program loader: the writer for the instruction memory that the nanoFOX core fetches from and the pipeline trace decodes. It receives a framed program image over an 8-bit valid/ready stream (driven by UART RX or a bench driver) and assembles 32-bit little-endian words. It writes them sequentially into the instruction memory write port and holds the CPU in reset until a frame is loaded with a correct checksum. It sits in nf_top between the host-side byte source and the instruction memory / cpu reset.

---
 rtl/nf_loader_pkg.sv | 11 +
 rtl/nf_prog_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/nf_loader_pkg.sv
// Shared types and constants for the nanoFOX program loader.
package nf_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } ld_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         BPOS_W        = 2;

endpackage

// File: rtl/nf_prog_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction
// memory and releases the CPU hold only after a frame with a good checksum.
module nf_prog_loader
  import nf_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  ld_state_e         state_q, state_d;
  logic [BPOS_W-1:0] bpos_q, bpos_d;
  logic [15:0]       widx_q, widx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       wbuf_q, wbuf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic [15:0]       n_new;

  assign n_new = {rx_data, cnt_q[7:0]};

  always_comb begin
    state_d = state_q;
    bpos_d  = bpos_q;
    widx_d  = widx_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    wbuf_d  = wbuf_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = S_CNT_LO;
        csum_d  = 8'h00;
        widx_d  = 16'd0;
        bpos_d  = '0;
        hold_d  = 1'b1;
      end
      S_CNT_LO: if (rx_valid) begin
        cnt_d[7:0] = rx_data;
        csum_d     = csum_q ^ rx_data;
        state_d    = S_CNT_HI;
      end
      S_CNT_HI: if (rx_valid) begin
        cnt_d[15:8] = rx_data;
        csum_d      = csum_q ^ rx_data;
        if ({1'b0, n_new} > MAX_N) state_d = S_ERR;
        else if (n_new == 16'd0)   state_d = S_CSUM;
        else                       state_d = S_DATA;
      end
      S_DATA: if (rx_valid) begin
        csum_d = csum_q ^ rx_data;
        bpos_d = bpos_q + BPOS_W'(1);
        case (bpos_q)
          2'd0: wbuf_d[7:0]   = rx_data;
          2'd1: wbuf_d[15:8]  = rx_data;
          2'd2: wbuf_d[23:16] = rx_data;
          default: begin
            // Write port is registered so the next byte can't disturb it.
            we_d    = 1'b1;
            addr_d  = widx_q[ADDR_W-1:0];
            wdata_d = {rx_data, wbuf_q};
            widx_d  = widx_q + 16'd1;
            if (widx_q == cnt_q - 16'd1) state_d = S_CSUM;
          end
        endcase
      end
      S_CSUM: if (rx_valid) begin
        state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      bpos_q  <= '0;
      widx_q  <= 16'd0;
      cnt_q   <= 16'd0;
      csum_q  <= 8'h00;
      wbuf_q  <= 24'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      bpos_q  <= bpos_d;
      widx_q  <= widx_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      wbuf_q  <= wbuf_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
    end
  end

  assign rx_ready  = 1'b1;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_hold  = hold_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);

endmodule
